// File: rtl/tt_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// tt_ctrl_pkg
// Shared definitions for the chip-level selection controller and anything that
// decodes the spine (row muxes, benches).
//   - ctrl_state_e : controller state encoding
//   - SEL_W        : width of the flat module select
//   - IW_* / OW_*  : bit positions of the fixed fields on the inward/outward
//                    spine buses; the user fields sit directly above them and
//                    the high guard is always the top bit of the bus.
// ----------------------------------------------------------------------------
package tt_ctrl_pkg;

   localparam int SEL_W = 10;

   // Inward spine: {gh, usr, sel[9:0], ena, gl}
   localparam int IW_GL_BIT  = 0;
   localparam int IW_ENA_BIT = 1;
   localparam int IW_SEL_LSB = 2;
   localparam int IW_USR_LSB = IW_SEL_LSB + SEL_W;

   // Outward spine: {gh, usr, gl}
   localparam int OW_GL_BIT  = 0;
   localparam int OW_USR_LSB = 1;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_BREAK  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_SETTLE = 2'd3
   } ctrl_state_e;

   // Select advance; 1023 wraps to 0 by plain modulo-2^SEL_W arithmetic.
   function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
      return s + 1'b1;
   endfunction

endpackage

// File: rtl/tt_ctrl_sync.sv
// ----------------------------------------------------------------------------
// tt_ctrl_sync
// Two-flop synchroniser for slow asynchronous pad strobes.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears both stages to 0
//   d_i  : asynchronous input(s)
//   q_o  : synchronised output(s), two clk edges behind d_i
// ----------------------------------------------------------------------------
module tt_ctrl_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/tt_ctrl_sel.sv
// ----------------------------------------------------------------------------
// tt_ctrl_sel
// Selection controller driving the vertical spine. Converts the slow pad
// strobes (select reset, select increment, enable) into a registered 10-bit
// module select and a glitch-free enable with break-before-make sequencing,
// and maps the chip I/O pads onto the spine user buses.
//   clk, rst       : clock, asynchronous active-high reset
//   pad_sel_rst_n  : async pad, low clears and holds the select at 0
//   pad_sel_inc    : async pad, each rising edge advances the select
//   pad_ena        : async pad, requests enable of the selected module
//   pad_ui_in      : dedicated input pads       -> spine_iw usr (low part)
//   pad_uio_in     : bidirectional pad inputs   -> spine_iw usr (high part)
//   pad_uo_out     : dedicated output pads      <- spine_ow usr[N_O-1:0]
//   pad_uio_out    : bidir pad output values    <- next N_IO usr bits
//   pad_uio_oe     : bidir pad output enables   <- top N_IO usr bits
//   spine_iw       : {gh, usr, sel, ena, gl}, guards driven 0
//   spine_ow       : {gh, usr, gl}, guards ignored
//   sel_addr       : current select (debug)
// ----------------------------------------------------------------------------
module tt_ctrl_sel
   import tt_ctrl_pkg::*;
#(
   parameter  int N_IO       = 8,
   parameter  int N_O        = 8,
   parameter  int N_I        = 10,
   parameter  int SETTLE_CYC = 4,
   localparam int U_IW       = N_I + N_IO,
   localparam int U_OW       = N_O + 2 * N_IO,
   localparam int S_IW       = U_IW + 13,
   localparam int S_OW       = U_OW + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pad_sel_rst_n,
   input  logic             pad_sel_inc,
   input  logic             pad_ena,
   input  logic [N_I-1:0]   pad_ui_in,
   input  logic [N_IO-1:0]  pad_uio_in,
   output logic [N_O-1:0]   pad_uo_out,
   output logic [N_IO-1:0]  pad_uio_out,
   output logic [N_IO-1:0]  pad_uio_oe,
   output logic [S_IW-1:0]  spine_iw,
   input  logic [S_OW-1:0]  spine_ow,
   output logic [SEL_W-1:0] sel_addr
);

   localparam int              CNT_W    = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);

   // ---------------- pad synchronisation ----------------
   logic s_rst_n, s_inc, s_ena;

   tt_ctrl_sync #(.W(1)) u_sync_rst_n (.clk(clk), .rst(rst), .d_i(pad_sel_rst_n), .q_o(s_rst_n));
   tt_ctrl_sync #(.W(1)) u_sync_inc   (.clk(clk), .rst(rst), .d_i(pad_sel_inc),   .q_o(s_inc));
   tt_ctrl_sync #(.W(1)) u_sync_ena   (.clk(clk), .rst(rst), .d_i(pad_ena),       .q_o(s_ena));

   logic inc_prev_q, inc_prev_d;
   logic inc_edge;

   assign inc_prev_d = s_inc;
   assign inc_edge   = s_inc & ~inc_prev_q;

   // ---------------- select / enable FSM ----------------
   ctrl_state_e      state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ena_q, ena_d;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_ACTIVE: begin
            if (!s_rst_n || inc_edge) state_d = ST_BREAK;
         end
         ST_BREAK: begin
            // Enable has just dropped; only now is the select allowed to move.
            if (!s_rst_n) begin
               sel_d   = '0;
               state_d = ST_HOLD;
            end else begin
               sel_d   = sel_inc(sel_q);
               cnt_d   = CNT_LOAD;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!s_rst_n) begin
               sel_d   = '0;
               state_d = ST_HOLD;
            end else if (inc_edge) begin
               // Enable is already low, so step directly and restart settling.
               sel_d = sel_inc(sel_q);
               cnt_d = CNT_LOAD;
            end else if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_ACTIVE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            sel_d = '0;
            if (s_rst_n) begin
               cnt_d   = CNT_LOAD;
               state_d = ST_SETTLE;
            end
         end
         default: state_d = ST_HOLD;
      endcase
      // Enable follows the next state so it drops in the same edge the FSM
      // leaves ACTIVE, one full cycle before the select can change.
      ena_d = (state_d == ST_ACTIVE) && s_ena;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_SETTLE;
         sel_q      <= '0;
         cnt_q      <= CNT_LOAD;
         ena_q      <= 1'b0;
         inc_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         ena_q      <= ena_d;
         inc_prev_q <= inc_prev_d;
      end
   end

   // ---------------- spine and pad mapping ----------------
   always_comb begin
      spine_iw                          = '0;   // guards gh/gl stay 0
      spine_iw[IW_ENA_BIT]              = ena_q;
      spine_iw[IW_SEL_LSB +: SEL_W]     = sel_q;
      spine_iw[IW_USR_LSB +: U_IW]      = {pad_uio_in, pad_ui_in};
   end

   assign pad_uo_out  = spine_ow[OW_USR_LSB +: N_O];
   assign pad_uio_out = spine_ow[OW_USR_LSB + N_O +: N_IO];
   assign pad_uio_oe  = spine_ow[OW_USR_LSB + N_O + N_IO +: N_IO];
   assign sel_addr    = sel_q;

   // Outward guard bits carry no information.
   logic [1:0] unused_ow_guards;
   assign unused_ow_guards = {spine_ow[S_OW-1], spine_ow[OW_GL_BIT]};

endmodule

// File: tb/tb_tt_ctrl_sel.sv
// ----------------------------------------------------------------------------
// tb_tt_ctrl_sel
// Directed bench for tt_ctrl_sel with default parameters (SETTLE_CYC = 4).
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point; "offset k" below means k rising edges after the change.
// ----------------------------------------------------------------------------
module tb_tt_ctrl_sel;

   localparam int N_IO = 8;
   localparam int N_O  = 8;
   localparam int N_I  = 10;
   localparam int S    = 4;
   localparam int S_IW = 31;
   localparam int S_OW = 26;

   logic             clk = 1'b0;
   logic             rst;
   logic             pad_sel_rst_n, pad_sel_inc, pad_ena;
   logic [N_I-1:0]   pad_ui_in;
   logic [N_IO-1:0]  pad_uio_in;
   logic [N_O-1:0]   pad_uo_out;
   logic [N_IO-1:0]  pad_uio_out, pad_uio_oe;
   logic [S_IW-1:0]  spine_iw;
   logic [S_OW-1:0]  spine_ow;
   logic [9:0]       sel_addr;

   tt_ctrl_sel #(.N_IO(N_IO), .N_O(N_O), .N_I(N_I), .SETTLE_CYC(S)) dut (
      .clk           (clk),
      .rst           (rst),
      .pad_sel_rst_n (pad_sel_rst_n),
      .pad_sel_inc   (pad_sel_inc),
      .pad_ena       (pad_ena),
      .pad_ui_in     (pad_ui_in),
      .pad_uio_in    (pad_uio_in),
      .pad_uo_out    (pad_uo_out),
      .pad_uio_out   (pad_uio_out),
      .pad_uio_oe    (pad_uio_oe),
      .spine_iw      (spine_iw),
      .spine_ow      (spine_ow),
      .sel_addr      (sel_addr)
   );

   always #5 clk = ~clk;

   wire       ena_w  = spine_iw[1];
   wire [9:0] sel_iw = spine_iw[11:2];

   int         checks = 0;
   int         errors = 0;
   logic [9:0] exp_sel;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Break-before-make watchdog: enable may only be high once the select has
   // been stable for at least S cycles.
   logic [9:0] mon_prev  = '0;
   int         mon_since = 0;
   always @(negedge clk) begin
      if (sel_addr !== mon_prev) mon_since = 0;
      else if (mon_since < 10000) mon_since = mon_since + 1;
      mon_prev = sel_addr;
      if (ena_w === 1'b1) check("bbm_stable", 32'(mon_since >= S), 32'd1);
   end

   // One increment pulse, 4 high / 4 low, starting in ACTIVE with enable on.
   task automatic inc_pulse();
      logic [9:0] base;
      base    = exp_sel;
      exp_sel = exp_sel + 10'd1;
      pad_sel_inc = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 4) pad_sel_inc = 1'b0;
         check("inc_ena", 32'(ena_w), (k <= 2 || k >= 4 + S) ? 32'd1 : 32'd0);
         check("inc_sel", 32'(sel_addr), (k >= 4) ? 32'(exp_sel) : 32'(base));
      end
      check("inc_spine_sel", 32'(sel_iw), 32'(exp_sel));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout t=%0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      rst           = 1'b1;
      pad_sel_rst_n = 1'b0;
      pad_sel_inc   = 1'b0;
      pad_ena       = 1'b1;
      pad_ui_in     = '0;
      pad_uio_in    = '0;
      spine_ow      = '0;
      exp_sel       = '0;

      // ---- reset state ----
      repeat (3) tick();
      $display("step reset");
      check("rst_sel", 32'(sel_addr), 32'd0);
      check("rst_ena", 32'(ena_w), 32'd0);
      check("rst_gh", 32'(spine_iw[30]), 32'd0);
      check("rst_gl", 32'(spine_iw[0]), 32'd0);
      rst = 1'b0;

      // ---- HOLD while pad_sel_rst_n low ----
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("hold_sel", 32'(sel_addr), 32'd0);
         check("hold_ena", 32'(ena_w), 32'd0);
      end

      // ---- release select reset: ena first 1 at offset S+3 ----
      $display("step release_sel_rst_n");
      pad_sel_rst_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("release_ena", 32'(ena_w), (k >= S + 3) ? 32'd1 : 32'd0);
         check("release_sel", 32'(sel_addr), 32'd0);
      end

      // ---- five increments ----
      for (int p = 0; p < 5; p++) begin
         inc_pulse();
         $display("inc5 pulse %0d sel=%0d", p, sel_addr);
      end
      check("inc5_sel", 32'(sel_addr), 32'd5);

      // ---- enable latency ----
      $display("step ena_latency");
      pad_ena = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("ena_fall", 32'(ena_w), (k <= 2) ? 32'd1 : 32'd0);
      end
      pad_ena = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("ena_rise", 32'(ena_w), (k >= 3) ? 32'd1 : 32'd0);
      end

      // ---- 1024 increments: full wrap back to 5 ----
      for (int p = 0; p < 1024; p++) begin
         inc_pulse();
         if (exp_sel == 10'd0) begin
            check("wrap_zero", 32'(sel_addr), 32'd0);
            $display("wrap reached sel=%0d", sel_addr);
         end
      end
      $display("step wrap done sel=%0d", sel_addr);
      check("wrap_final", 32'(sel_addr), 32'd5);

      // ---- select reset coincident with increment edge ----
      $display("step rst_n_with_inc");
      pad_sel_inc   = 1'b1;
      pad_sel_rst_n = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 4) pad_sel_inc = 1'b0;
         check("rstinc_ena", 32'(ena_w), (k <= 2) ? 32'd1 : 32'd0);
         check("rstinc_sel", 32'(sel_addr), (k >= 4) ? 32'd0 : 32'd5);
      end
      exp_sel = '0;
      pad_sel_rst_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("rstinc_rel_ena", 32'(ena_w), (k >= S + 3) ? 32'd1 : 32'd0);
         check("rstinc_rel_sel", 32'(sel_addr), 32'd0);
      end

      // ---- increment during SETTLE: no BREAK, counter restarts ----
      $display("step inc_in_settle");
      pad_sel_inc = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 2) pad_sel_inc = 1'b0;
         if (k == 4) pad_sel_inc = 1'b1;
         if (k == 8) pad_sel_inc = 1'b0;
         check("settle_inc_sel", 32'(sel_addr), (k >= 7) ? 32'd2 : ((k >= 4) ? 32'd1 : 32'd0));
         check("settle_inc_ena", 32'(ena_w), (k <= 2 || k >= 7 + S) ? 32'd1 : 32'd0);
      end
      exp_sel = 10'd2;

      // ---- pad pass-through ----
      for (int i = 0; i < 8; i++) begin
         logic [17:0] exp_usr;
         if (i == 0) begin
            pad_ui_in = '1; pad_uio_in = '1; spine_ow = '1;
         end else if (i == 1) begin
            pad_ui_in = 10'h155; pad_uio_in = 8'h2A; spine_ow = 26'h2AA_AAAA;
         end else begin
            pad_ui_in  = 10'($urandom);
            pad_uio_in = 8'($urandom);
            spine_ow   = 26'($urandom);
         end
         #1;
         exp_usr = {pad_uio_in, pad_ui_in};
         $display("pass %0d ui=%h uio=%h ow=%h", i, pad_ui_in, pad_uio_in, spine_ow);
         check("pt_usr", 32'(spine_iw[29:12]), 32'(exp_usr));
         check("pt_gh", 32'(spine_iw[30]), 32'd0);
         check("pt_gl", 32'(spine_iw[0]), 32'd0);
         check("pt_uo", 32'(pad_uo_out), 32'(spine_ow[8:1]));
         check("pt_uio_out", 32'(pad_uio_out), 32'(spine_ow[16:9]));
         check("pt_uio_oe", 32'(pad_uio_oe), 32'(spine_ow[24:17]));
         tick();
      end

      // ---- asynchronous rst mid-settle ----
      $display("step rst_mid_settle");
      pad_sel_inc = 1'b1;
      repeat (5) tick();
      check("mid_sel_before", 32'(sel_addr), 32'd3);
      check("mid_ena_before", 32'(ena_w), 32'd0);
      pad_sel_inc = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_sel", 32'(sel_addr), 32'd0);
      check("mid_rst_spine_sel", 32'(sel_iw), 32'd0);
      check("mid_rst_ena", 32'(ena_w), 32'd0);
      tick();
      rst = 1'b0;
      begin
         int n;
         n = 0;
         while (ena_w !== 1'b1 && n < 30) begin
            tick();
            n++;
         end
         check("post_rst_ena_cycles", 32'(n), 32'd7);
         check("post_rst_sel", 32'(sel_addr), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
